// File: rtl/lc3b_types.sv
// Shared types for the LC-3b branch prediction path.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    logic     pred;
  } lc3b_bq_entry;

  typedef enum logic {
    BPC_TRACK   = 1'b0,
    BPC_RECOVER = 1'b1
  } bpc_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/branch_tracking_queue.sv
// In-order circular queue of in-flight branches {pc, pred}.
// Latency: head visible combinationally; push/pop/clear take effect on the next edge.
// Backpressure: push ignored when full, pop ignored when empty, clear overrides both.
module branch_tracking_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  lc3b_bq_entry             push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output lc3b_bq_entry             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  lc3b_bq_entry  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[tail] <= push_dat;
  end

endmodule

// File: rtl/branch_prediction_controller.sv
// Tracks branches fetch->writeback and issues predictor update/mispredict strobes.
// Latency: lookup_pc/fetch_stall combinational; resolve to strobes is 1 cycle.
// Backpressure: fetch_stall while the queue is full or during post-mispredict recovery.
module branch_prediction_controller
  import lc3b_types::*;
#(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_is_branch,
  input  lc3b_word    fetch_pc,
  input  logic        predict_taken,
  output lc3b_word    lookup_pc,
  output logic        fetch_stall,
  input  logic        wb_branch_valid,
  input  logic        wb_take_jump,
  output logic        update_branch_history,
  output lc3b_word    resolved_pc,
  output logic        resolved_taken,
  output logic        mispredict,
  output logic        protocol_error,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(RECOVER_CYCLES) + 1;

  bpc_state_t    state;
  logic [RW-1:0] rec_cnt;

  lc3b_bq_entry  push_dat;
  lc3b_bq_entry  head_dat;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;

  logic push_ok;
  logic pop_ok;
  logic mis_now;

  assign lookup_pc   = fetch_pc;
  assign fetch_stall = q_full || (state == BPC_RECOVER);
  assign push_ok     = fetch_is_branch && !fetch_stall;
  assign pop_ok      = wb_branch_valid && (q_count != '0);
  assign mis_now     = pop_ok && (wb_take_jump != head_dat.pred);
  assign push_dat    = '{pc: fetch_pc, pred: predict_taken};

  // A mispredict flushes everything younger, including a same-cycle push.
  branch_tracking_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push_ok && !mis_now),
    .push_dat (push_dat),
    .pop      (pop_ok),
    .clear    (mis_now),
    .head_dat (head_dat),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= BPC_TRACK;
      rec_cnt               <= '0;
      update_branch_history <= 1'b0;
      resolved_pc           <= '0;
      resolved_taken        <= 1'b0;
      mispredict            <= 1'b0;
      protocol_error        <= 1'b0;
      branch_count          <= '0;
      mispredict_count      <= '0;
    end else begin
      update_branch_history <= pop_ok;
      mispredict            <= mis_now;
      if (pop_ok) begin
        resolved_pc    <= head_dat.pc;
        resolved_taken <= wb_take_jump;
        branch_count   <= sat_inc16(branch_count);
      end
      if (mis_now) mispredict_count <= sat_inc16(mispredict_count);
      if (wb_branch_valid && q_empty) protocol_error <= 1'b1;

      case (state)
        BPC_TRACK: begin
          if (mis_now) begin
            state   <= BPC_RECOVER;
            rec_cnt <= RW'(RECOVER_CYCLES - 1);
          end
        end
        BPC_RECOVER: begin
          if (rec_cnt == '0) state <= BPC_TRACK;
          else               rec_cnt <= rec_cnt - 1'b1;
        end
        default: state <= BPC_TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_prediction_controller.sv
// Directed plus randomized bench for branch_prediction_controller against a queue-based model.
module tb_branch_prediction_controller;
  localparam int DEPTH = 4;
  localparam int RECOVER_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_is_branch = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic        predict_taken = 1'b0;
  logic [15:0] lookup_pc;
  logic        fetch_stall;
  logic        wb_branch_valid = 1'b0;
  logic        wb_take_jump = 1'b0;
  logic        update_branch_history;
  logic [15:0] resolved_pc;
  logic        resolved_taken;
  logic        mispredict;
  logic        protocol_error;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  always #5 clk = ~clk;

  branch_prediction_controller #(.DEPTH(DEPTH), .RECOVER_CYCLES(RECOVER_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .fetch_is_branch(fetch_is_branch), .fetch_pc(fetch_pc), .predict_taken(predict_taken),
    .lookup_pc(lookup_pc), .fetch_stall(fetch_stall),
    .wb_branch_valid(wb_branch_valid), .wb_take_jump(wb_take_jump),
    .update_branch_history(update_branch_history), .resolved_pc(resolved_pc),
    .resolved_taken(resolved_taken), .mispredict(mispredict), .protocol_error(protocol_error),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight branches as a plain queue, {pc, pred}.
  logic [16:0] m_q[$];
  int          m_rec;
  int          m_bc, m_mc;
  bit          m_perr;
  bit          e_upd, e_mis, e_taken;
  logic [15:0] e_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rec = 0; m_bc = 0; m_mc = 0; m_perr = 0;
    e_upd = 0; e_mis = 0; e_taken = 0; e_pc = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fetch_is_branch = 0; wb_branch_valid = 0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, step model, check registered outputs.
  task automatic step(input bit fb, input logic [15:0] pc, input bit pt,
                      input bit wb, input bit take, input bit do_chk);
    bit stall, push, mis;
    logic [16:0] e;
    @(negedge clk);
    fetch_is_branch = fb; fetch_pc = pc; predict_taken = pt;
    wb_branch_valid = wb; wb_take_jump = take;
    #1;
    stall = (m_q.size() == DEPTH) || (m_rec > 0);
    if (do_chk) begin
      check("fetch_stall", fetch_stall, stall);
      check("lookup_pc", lookup_pc, pc);
    end
    push = fb && !stall;
    mis = 0;
    e_upd = 0;
    if (wb) begin
      if (m_q.size() == 0) begin
        m_perr = 1;
      end else begin
        e = m_q.pop_front();
        e_upd = 1; e_pc = e[16:1]; e_taken = take;
        mis = (take != e[0]);
        if (m_bc < 65535) m_bc++;
        if (mis) begin
          if (m_mc < 65535) m_mc++;
          m_q.delete();
          push = 0;
        end
      end
    end
    e_mis = mis;
    if (push) m_q.push_back({pc, pt});
    if (m_rec > 0) m_rec--;
    if (mis) m_rec = RECOVER_CYCLES;
    @(posedge clk);
    #1;
    if (do_chk) begin
      check("update_branch_history", update_branch_history, e_upd);
      check("mispredict", mispredict, e_mis);
      check("protocol_error", protocol_error, m_perr);
      check("branch_count", branch_count, m_bc);
      check("mispredict_count", mispredict_count, m_mc);
      if (e_upd) begin
        check("resolved_pc", resolved_pc, e_pc);
        check("resolved_taken", resolved_taken, e_taken);
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #1;
    check("rst_upd", update_branch_history, 0);
    check("rst_stall", fetch_stall, 0);
    check("rst_pc", resolved_pc, 0);
    check("rst_bc", branch_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single correctly predicted branch.
    step(1, 16'h0040, 1, 0, 0, 1);
    step(0, 16'h0000, 0, 1, 1, 1);
    check("t1_pc", resolved_pc, 16'h0040);

    // Fill, overflow attempt, drain in order, refill across the wrap.
    for (int i = 0; i < DEPTH; i++) step(1, 16'h0100 + 16'(i*2), i[0], 0, 0, 1);
    check("t2_full_stall", fetch_stall, 1);
    step(1, 16'h0BAD, 1, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 0, 1, i[0], 1);
    for (int i = 0; i < DEPTH; i++) step(1, 16'h0200 + 16'(i*2), 1, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 0, 1, 1, 1);

    // Mispredict with a same-cycle push; stall for RECOVER_CYCLES then accept.
    step(1, 16'h0300, 0, 0, 0, 1);
    step(1, 16'h0302, 1, 0, 0, 1);
    step(1, 16'h0304, 1, 0, 0, 1);
    step(1, 16'h0306, 1, 1, 1, 1);
    for (int i = 0; i < RECOVER_CYCLES + 2; i++) step(1, 16'h0400 + 16'(i*2), 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 16'h0, 0, 1, 1, 1);

    // Same-cycle push and pop at count 2.
    step(1, 16'h0500, 1, 0, 0, 1);
    step(1, 16'h0502, 0, 0, 0, 1);
    step(1, 16'h0504, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 1, (i == 1) ? 1'b0 : 1'b1, 1);

    // Resolve on empty queue: sticky error, no strobe.
    step(0, 16'h0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 0, 0, 1);
    do_reset();
    check("perr_cleared", protocol_error, 0);

    // Saturate branch_count with back-to-back push+pop.
    step(1, 16'h0600, 0, 0, 0, 1);
    for (int i = 0; i < 65536; i++) step(1, 16'(i), 0, 1, 0, 0);
    step(0, 16'h0, 0, 0, 0, 1);
    check("bc_saturated", branch_count, 16'hFFFF);
    step(0, 16'h0, 0, 1, 0, 1);
    check("bc_still_sat", branch_count, 16'hFFFF);

    // Mispredict, then asynchronous reset mid-recovery.
    do_reset();
    step(1, 16'h0700, 1, 0, 0, 1);
    step(0, 16'h0, 0, 1, 0, 1);
    check("rec_stall", fetch_stall, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_stall", fetch_stall, 0);
    check("arst_mis", mispredict, 0);
    check("arst_upd", update_branch_history, 0);
    check("arst_bc", branch_count, 0);
    check("arst_mc", mispredict_count, 0);
    check("arst_rpc", resolved_pc, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom % 3) != 0, 16'($urandom), $urandom % 2, ($urandom % 2) == 1, $urandom % 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
